// File: rtl/bounce_if.sv
// Level-in / bouncing-level-out bundle between a test source and the bounce emulator.
interface bounce_if;
  logic press;
  logic button;
  logic busy;
  logic done;

  modport master (output press, input  button, input  busy, input  done);
  modport slave  (input  press, output button, output busy, output done);
endinterface

// File: rtl/bounce_emulator.sv
// Turns each level change on press into an odd burst of LFSR-spaced toggles on button,
// always settling at the current press level.
module bounce_emulator #(
  parameter int          N_BOUNCES = 4,
  parameter int          GAP_W     = 4,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input  logic    clock,
  input  logic    reset,
  bounce_if.slave bif
);

  localparam int         REM_W    = $clog2(2*N_BOUNCES+2);
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [REM_W-1:0] REM_FULL = REM_W'(2*N_BOUNCES);

  typedef enum logic {IDLE, BOUNCE} state_t;

  state_t             state_q,  state_d;
  logic               button_q, button_d;
  logic               target_q, target_d;
  logic               done_q,   done_d;
  logic [7:0]         lfsr_q,   lfsr_d;
  logic [REM_W-1:0]   rem_q,    rem_d;
  logic [GAP_W-1:0]   gap_q,    gap_d;

  // Galois LFSR runs every cycle regardless of state so spacing stays decorrelated.
  assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

  always_comb begin
    state_d  = state_q;
    button_d = button_q;
    target_d = target_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bif.press != button_q) begin
          target_d = bif.press;
          button_d = ~button_q;
          rem_d    = REM_FULL;
          gap_d    = lfsr_q[GAP_W-1:0];
          state_d  = BOUNCE;
        end
      end
      BOUNCE: begin
        if (bif.press != target_q) begin
          // Extra toggle when button sits on the wrong side keeps the final level on press.
          target_d = bif.press;
          rem_d    = REM_FULL + REM_W'(button_q != bif.press);
          gap_d    = lfsr_q[GAP_W-1:0];
        end else if (rem_q == '0) begin
          state_d  = IDLE;
          done_d   = 1'b1;
        end else if (gap_q == '0) begin
          button_d = ~button_q;
          rem_d    = rem_q - REM_W'(1);
          gap_d    = lfsr_q[GAP_W-1:0];
        end else begin
          gap_d    = gap_q - GAP_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      button_q <= 1'b0;
      target_q <= 1'b0;
      done_q   <= 1'b0;
      lfsr_q   <= SEED_EFF;
      rem_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      button_q <= button_d;
      target_q <= target_d;
      done_q   <= done_d;
      lfsr_q   <= lfsr_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
    end
  end

  assign bif.button = button_q;
  assign bif.busy   = (state_q == BOUNCE);
  assign bif.done   = done_q;

endmodule

// File: tb/tb_bounce_emulator.sv
// Randomized bench for bounce_emulator: toggle times predicted from an LFSR table indexed by cycle.
module tb_bounce_emulator;

  localparam int MAXK = 65536;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  bounce_if m_if ();
  bounce_if n0_if ();
  bounce_if s0_if ();
  bounce_if s1_if ();

  bounce_emulator dut (.clock(clock), .reset(rst), .bif(m_if.slave));
  bounce_emulator #(.N_BOUNCES(0)) dut_n0 (.clock(clock), .reset(rst), .bif(n0_if.slave));
  bounce_emulator #(.SEED(8'h00)) dut_s0 (.clock(clock), .reset(rst), .bif(s0_if.slave));
  bounce_emulator #(.SEED(8'h01)) dut_s1 (.clock(clock), .reset(rst), .bif(s1_if.slave));

  int checks = 0;
  int errors = 0;
  int kcnt   = 0;        // number of non-reset edges since the last reset edge
  logic [7:0] lf [MAXK]; // LFSR value seen at non-reset edge k

  always @(posedge clock) kcnt <= rst ? 0 : kcnt + 1;

  function automatic logic [7:0] lstep(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clock);
    rst = 1'b0;
  endtask

  // Drives a new level and checks the full episode against predicted toggle edges.
  task automatic run_episode(input logic lvl, input string nm);
    int pred[$];
    int e, t, edg, last, toggles, mis, bad_int, done_cnt, done_edge, busy_bad;
    logic prev;
    m_if.press = lvl;
    e = kcnt;
    t = e;
    pred.push_back(t);
    for (int i = 1; i <= 8; i++) begin
      t = t + int'(lf[t][3:0]) + 1;
      pred.push_back(t);
    end
    prev = m_if.button; last = 0; toggles = 0; mis = 0; bad_int = 0;
    done_cnt = 0; done_edge = -1; busy_bad = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      edg = kcnt - 1;
      if (m_if.button !== prev) begin
        if (toggles >= 9 || pred[toggles] != edg) mis++;
        if (toggles > 0 && (edg - last < 1 || edg - last > 16)) bad_int++;
        last = edg; toggles++; prev = m_if.button;
      end
      if (m_if.done === 1'b1) begin done_cnt++; done_edge = edg; end
      if (edg <= t && m_if.busy !== 1'b1) busy_bad++;
      if (edg > t && m_if.busy !== 1'b0) busy_bad++;
      if (edg >= t + 3) break;
    end
    checks++; if (toggles !== 9) begin errors++; $display("FAIL %s toggle_count: got %0d want 9", nm, toggles); end
    checks++; if (mis !== 0) begin errors++; $display("FAIL %s toggle_times: %0d toggles off prediction, want 0", nm, mis); end
    checks++; if (bad_int !== 0) begin errors++; $display("FAIL %s interval_range: %0d intervals outside 1..16, want 0", nm, bad_int); end
    checks++; if (m_if.button !== lvl) begin errors++; $display("FAIL %s final_level: got %b want %b", nm, m_if.button, lvl); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s done_count: got %0d want 1", nm, done_cnt); end
    checks++; if (done_edge !== t + 1) begin errors++; $display("FAIL %s done_edge: got %0d want %0d", nm, done_edge, t + 1); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL %s busy_window: %0d bad cycles, want 0", nm, busy_bad); end
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++; if ({m_if.button, m_if.busy, m_if.done} !== 3'b000) begin errors++; $display("FAIL reset_main: got %b want 000", {m_if.button, m_if.busy, m_if.done}); end
    checks++; if ({n0_if.button, n0_if.busy, n0_if.done} !== 3'b000) begin errors++; $display("FAIL reset_n0: got %b want 000", {n0_if.button, n0_if.busy, n0_if.done}); end
    checks++; if ({s0_if.button, s0_if.busy, s0_if.done, s1_if.button, s1_if.busy, s1_if.done} !== 6'b0) begin
      errors++; $display("FAIL reset_seeds: got %b want 000000", {s0_if.button, s0_if.busy, s0_if.done, s1_if.button, s1_if.busy, s1_if.done}); end
  endtask

  task automatic test_first_episode();
    int quiet_bad;
    quiet_bad = 0;
    // press held low in idle: nothing should move
    repeat (7) begin
      @(negedge clock);
      if ({m_if.button, m_if.busy, m_if.done} !== 3'b000) quiet_bad++;
    end
    checks++; if (quiet_bad !== 0) begin errors++; $display("FAIL idle_quiet: %0d active cycles, want 0", quiet_bad); end
    run_episode(1'b1, "first_episode");
  endtask

  task automatic test_random_gaps();
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge clock);
      run_episode(~m_if.button, "random_gap");
    end
  endtask

  task automatic test_reversal();
    int toggles, after, dn, c;
    logic prev;
    do_reset(2);
    m_if.press = 1'b1;
    prev = m_if.button; toggles = 0; dn = 0; c = 0;
    while (toggles < 3 && c < 200) begin
      @(negedge clock); c++;
      if (m_if.button !== prev) begin toggles++; prev = m_if.button; end
      if (m_if.done === 1'b1) dn++;
    end
    checks++; if (toggles !== 3 || m_if.button !== 1'b1) begin errors++; $display("FAIL reversal_pre: toggles %0d button %b want 3 and 1", toggles, m_if.button); end
    m_if.press = 1'b0;
    after = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (m_if.button !== prev) begin after++; prev = m_if.button; end
      if (m_if.done === 1'b1) dn++;
      if (m_if.busy === 1'b0 && m_if.done === 1'b0 && dn > 0) break;
    end
    checks++; if (after !== 9) begin errors++; $display("FAIL reversal_toggles: got %0d want 9", after); end
    checks++; if (m_if.button !== 1'b0) begin errors++; $display("FAIL reversal_final: got %b want 0", m_if.button); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL reversal_done_count: got %0d want 1", dn); end
  endtask

  task automatic test_n0();
    n0_if.press = 1'b1;
    @(negedge clock);
    checks++; if ({n0_if.button, n0_if.busy, n0_if.done} !== 3'b110) begin errors++; $display("FAIL n0_toggle: got %b want 110", {n0_if.button, n0_if.busy, n0_if.done}); end
    @(negedge clock);
    checks++; if ({n0_if.button, n0_if.busy, n0_if.done} !== 3'b101) begin errors++; $display("FAIL n0_done: got %b want 101", {n0_if.button, n0_if.busy, n0_if.done}); end
    @(negedge clock);
    checks++; if ({n0_if.button, n0_if.busy, n0_if.done} !== 3'b100) begin errors++; $display("FAIL n0_settle: got %b want 100", {n0_if.button, n0_if.busy, n0_if.done}); end
  endtask

  task automatic test_reset_mid();
    int toggles, c;
    logic prev;
    do_reset(2);
    m_if.press = 1'b1;
    prev = m_if.button; toggles = 0; c = 0;
    while (toggles < 2 && c < 200) begin
      @(negedge clock); c++;
      if (m_if.button !== prev) begin toggles++; prev = m_if.button; end
    end
    rst = 1'b1;
    @(negedge clock);
    checks++; if ({m_if.button, m_if.busy, m_if.done} !== 3'b000) begin errors++; $display("FAIL reset_mid: got %b want 000", {m_if.button, m_if.busy, m_if.done}); end
    rst = 1'b0;
    run_episode(1'b1, "after_reset");
  endtask

  task automatic test_repeat();
    logic st [300];
    logic tr1 [300];
    int rep_diff, seed_diff, tog1;
    logic p;
    p = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) p = ~p;
      st[i] = p;
    end
    st[5] = 1'b1; st[6] = 1'b1;
    rep_diff = 0; seed_diff = 0; tog1 = 0;
    for (int run = 0; run < 2; run++) begin
      m_if.press = 1'b0; s0_if.press = 1'b0; s1_if.press = 1'b0;
      do_reset(2);
      for (int i = 0; i < 300; i++) begin
        m_if.press = st[i]; s0_if.press = st[i]; s1_if.press = st[i];
        @(negedge clock);
        if (run == 0) begin
          tr1[i] = m_if.button;
          if (i > 0 && tr1[i] !== tr1[i-1]) tog1++;
        end else if (m_if.button !== tr1[i]) rep_diff++;
        if ({s0_if.button, s0_if.busy, s0_if.done} !== {s1_if.button, s1_if.busy, s1_if.done}) seed_diff++;
      end
    end
    checks++; if (tog1 < 9) begin errors++; $display("FAIL repeat_activity: got %0d toggles want >=9", tog1); end
    checks++; if (rep_diff !== 0) begin errors++; $display("FAIL repeat_trace: %0d differing cycles, want 0", rep_diff); end
    checks++; if (seed_diff !== 0) begin errors++; $display("FAIL seed0_vs_seed1: %0d differing cycles, want 0", seed_diff); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    m_if.press = 1'b0; n0_if.press = 1'b0; s0_if.press = 1'b0; s1_if.press = 1'b0;
    lf[0] = 8'hA5;
    for (int k = 1; k < MAXK; k++) lf[k] = lstep(lf[k-1]);
    test_reset();
    test_first_episode();
    test_random_gaps();
    test_reversal();
    test_n0();
    test_reset_mid();
    test_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
